// File: rtl/bm_gauss_combiner.sv
// rtl/bm_gauss_combiner.sv - Box-Muller output stage: f*g products, round/saturate, warm-up discard, output FIFO
//
// Purpose:
//   Multiplies the radius term f by the sin/cos terms g0/g1. The g terms are
//   delayed by G_DLY accepted samples so that they line up with f. Each
//   product is rounded half-up by SHIFT bits and saturated to OUT_W bits.
//   The first WARMUP accepted samples after reset/flush are discarded. The
//   remaining result pairs are queued in a DEPTH-entry first-word-fall-through
//   FIFO with a ready/valid output.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   flush        in   synchronous clear of delay line, warm-up, product stage, FIFO
//   in_en        in   sample accept strobe
//   f_in         in   signed radius term            [F_W]
//   g0_in/g1_in  in   signed cos/sin terms          [G_W]
//   out_valid    out  FIFO head valid
//   out_ready    in   consumer accepts
//   x0_out       out  result 0 (MODE 1: serial x0 then x1)  [OUT_W]
//   x1_out       out  result 1 (MODE 1: always 0)           [OUT_W]
//   out_sel      out  MODE 1 half being presented (0 = x0, 1 = x1)
//   almost_full  out  FIFO count >= DEPTH-2 (registered)
//   sat          out  one-cycle pulse when a kept product pair clamped
//   drop_cnt     out  saturating count of pairs dropped on a full FIFO

module bm_gauss_combiner #(
  parameter int F_W    = 17,
  parameter int G_W    = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int G_DLY  = 12,
  parameter int WARMUP = 15,
  parameter int DEPTH  = 8,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_en,
  input  logic signed [F_W-1:0]   f_in,
  input  logic signed [G_W-1:0]   g0_in,
  input  logic signed [G_W-1:0]   g1_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] x0_out,
  output logic signed [OUT_W-1:0] x1_out,
  output logic                    out_sel,
  output logic                    almost_full,
  output logic                    sat,
  output logic [15:0]             drop_cnt
);

  // One extra bit above the full product width so the rounding add cannot wrap.
  localparam int P_W  = F_W + G_W;
  localparam int R_W  = P_W + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  localparam logic signed [R_W-1:0] RND   = R_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [R_W-1:0] MAX_R = R_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [R_W-1:0] MIN_R = R_W'(-(64'sd1 <<< (OUT_W - 1)));

  // ---------------------------------------------------------------------------
  // Rounding and saturation of one product
  // ---------------------------------------------------------------------------
  function automatic logic signed [OUT_W-1:0] round_sat(
    input  logic signed [F_W-1:0] f,
    input  logic signed [G_W-1:0] g,
    output logic                  clamped
  );
    logic signed [R_W-1:0] p;
    logic signed [R_W-1:0] r;
    p = R_W'(f) * R_W'(g);
    p = p + RND;
    r = p >>> SHIFT;
    clamped = 1'b0;
    if (r > MAX_R) begin
      r       = MAX_R;
      clamped = 1'b1;
    end else if (r < MIN_R) begin
      r       = MIN_R;
      clamped = 1'b1;
    end
    return OUT_W'(r);
  endfunction

  // ---------------------------------------------------------------------------
  // g delay line: advances only on accepted samples. It is cleared to zero,
  // so the tap naturally reads 0 until G_DLY samples have been accepted.
  // ---------------------------------------------------------------------------
  logic signed [G_W-1:0] dly0_q [G_DLY];
  logic signed [G_W-1:0] dly1_q [G_DLY];
  logic signed [G_W-1:0] gd0;
  logic signed [G_W-1:0] gd1;

  assign gd0 = dly0_q[G_DLY-1];
  assign gd1 = dly1_q[G_DLY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < G_DLY; i++) begin
        dly0_q[i] <= '0;
        dly1_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < G_DLY; i++) begin
        dly0_q[i] <= '0;
        dly1_q[i] <= '0;
      end
    end else if (in_en) begin
      dly0_q[0] <= g0_in;
      dly1_q[0] <= g1_in;
      for (int i = 1; i < G_DLY; i++) begin
        dly0_q[i] <= dly0_q[i-1];
        dly1_q[i] <= dly1_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Warm-up counter: saturates at WARMUP. Samples are kept once it has saturated.
  // ---------------------------------------------------------------------------
  logic [WC_W-1:0] warm_q;
  logic            warm_done;

  assign warm_done = (warm_q == WC_W'(WARMUP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
    end else if (flush) begin
      warm_q <= '0;
    end else if (in_en && !warm_done) begin
      warm_q <= warm_q + WC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Product stage
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] prod_x0_d, prod_x1_d;
  logic signed [OUT_W-1:0] prod_x0_q, prod_x1_q;
  logic                    clamp0, clamp1;
  logic                    prod_v_q;
  logic                    sat_q;

  always_comb begin
    clamp0    = 1'b0;
    clamp1    = 1'b0;
    prod_x0_d = round_sat(f_in, gd0, clamp0);
    prod_x1_d = round_sat(f_in, gd1, clamp1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_v_q  <= 1'b0;
      sat_q     <= 1'b0;
      prod_x0_q <= '0;
      prod_x1_q <= '0;
    end else if (flush) begin
      prod_v_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      prod_v_q <= in_en && warm_done;
      // Discarded warm-up samples never raise sat.
      sat_q    <= in_en && warm_done && (clamp0 || clamp1);
      if (in_en) begin
        prod_x0_q <= prod_x0_d;
        prod_x1_q <= prod_x1_d;
      end
    end
  end

  assign sat = sat_q;

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] mem0_q [DEPTH];
  logic signed [OUT_W-1:0] mem1_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    out_sel_q;
  logic                    almost_full_q;
  logic [15:0]             drop_cnt_q;
  logic                    xfer, pop, push, drop;

  assign out_valid = (count_q != '0);
  assign xfer      = out_valid && out_ready;
  // In MODE 1 an entry leaves only once its second half (x1) has transferred.
  assign pop       = xfer && ((MODE == 0) || out_sel_q);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push      = prod_v_q && ((count_q != CW'(DEPTH)) || pop);
  assign drop      = prod_v_q && !push;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem0_q[wr_ptr_q] <= prod_x0_q;
      mem1_q[wr_ptr_q] <= prod_x1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_sel_q     <= 1'b0;
      almost_full_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_sel_q     <= 1'b0;
      almost_full_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      almost_full_q <= (count_d >= CW'(DEPTH - 2));
      if (xfer && (MODE != 0)) out_sel_q <= ~out_sel_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Head data is gated by out_valid so stale storage never shows after reset/flush.
  always_comb begin
    x0_out = '0;
    x1_out = '0;
    if (out_valid) begin
      if (MODE == 0) begin
        x0_out = mem0_q[rd_ptr_q];
        x1_out = mem1_q[rd_ptr_q];
      end else begin
        x0_out = out_sel_q ? mem1_q[rd_ptr_q] : mem0_q[rd_ptr_q];
      end
    end
  end

  assign out_sel     = out_sel_q;
  assign almost_full = almost_full_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_bm_gauss_combiner.sv
// tb/tb_bm_gauss_combiner.sv - randomized and directed bench for bm_gauss_combiner against a queue-based reference model
//
// Three instances share the sample inputs; each one has its own out_ready:
//   u0: defaults (G_DLY=12, WARMUP=15, MODE 0)
//   u1: G_DLY=1, WARMUP=0, MODE 0
//   u2: G_DLY=1, WARMUP=0, MODE 1

module tb_bm_gauss_combiner;

  localparam int NI    = 3;
  localparam int DEPTH = 8;
  localparam int SHIFT = 15;
  localparam int OUT_W = 16;

  logic               clk = 1'b0;
  logic               reset, flush, in_en;
  logic signed [16:0] f_in;
  logic signed [15:0] g0_in, g1_in;
  logic               rdy  [NI];
  logic               ov   [NI];
  logic signed [15:0] x0   [NI];
  logic signed [15:0] x1   [NI];
  logic               sel  [NI];
  logic               af   [NI];
  logic               sat  [NI];
  logic [15:0]        drop [NI];

  always #5 clk = ~clk;

  bm_gauss_combiner u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_en(in_en),
    .f_in(f_in), .g0_in(g0_in), .g1_in(g1_in),
    .out_valid(ov[0]), .out_ready(rdy[0]), .x0_out(x0[0]), .x1_out(x1[0]),
    .out_sel(sel[0]), .almost_full(af[0]), .sat(sat[0]), .drop_cnt(drop[0]));

  bm_gauss_combiner #(.G_DLY(1), .WARMUP(0), .MODE(0)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_en(in_en),
    .f_in(f_in), .g0_in(g0_in), .g1_in(g1_in),
    .out_valid(ov[1]), .out_ready(rdy[1]), .x0_out(x0[1]), .x1_out(x1[1]),
    .out_sel(sel[1]), .almost_full(af[1]), .sat(sat[1]), .drop_cnt(drop[1]));

  bm_gauss_combiner #(.G_DLY(1), .WARMUP(0), .MODE(1)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_en(in_en),
    .f_in(f_in), .g0_in(g0_in), .g1_in(g1_in),
    .out_valid(ov[2]), .out_ready(rdy[2]), .x0_out(x0[2]), .x1_out(x1[2]),
    .out_sel(sel[2]), .almost_full(af[2]), .sat(sat[2]), .drop_cnt(drop[2]));

  function automatic int dly_of(int i);  return (i == 0) ? 12 : 1; endfunction
  function automatic int warm_of(int i); return (i == 0) ? 15 : 0; endfunction
  function automatic int mode_of(int i); return (i == 2) ? 1 : 0;  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact product, floor((P + 2^(SHIFT-1)) / 2^SHIFT), then clamp.
  function automatic int ref_round(input longint f, input longint g, output bit c);
    longint den, num, q, lim;
    den = longint'(1) << SHIFT;
    num = f * g + den / 2;
    if (num >= 0) q = num / den;
    else          q = -((-num + den - 1) / den);
    lim = longint'(1) << (OUT_W - 1);
    c = 1'b0;
    if (q > lim - 1) begin q = lim - 1; c = 1'b1; end
    else if (q < -lim) begin q = -lim; c = 1'b1; end
    return int'(q);
  endfunction

  // Model state
  int acc_g0[$], acc_g1[$];
  int fq_a [NI][$];
  int fq_b [NI][$];
  bit m_pend [NI];
  int m_pa [NI], m_pb [NI];
  bit m_sel [NI], m_sat [NI];
  int m_drop [NI];

  // Capture of transfers and sat pulses for the directed phases
  bit cap_on = 1'b0;
  int cap_i  = 0;
  int cap_x[$], cap_s[$];
  int n_sat  = 0;
  int rec_f[$], rec_g0[$], rec_g1[$];

  task automatic model_reset();
    acc_g0.delete();
    acc_g1.delete();
    for (int i = 0; i < NI; i++) begin
      fq_a[i].delete();
      fq_b[i].delete();
      m_pend[i] = 1'b0;
      m_sel[i]  = 1'b0;
      m_sat[i]  = 1'b0;
      m_drop[i] = 0;
    end
  endtask

  task automatic model_step();
    int k, ga, gb, ra, rb;
    bit ca, cb;
    k = acc_g0.size();
    for (int i = 0; i < NI; i++) begin
      if (flush) begin
        fq_a[i].delete();
        fq_b[i].delete();
        m_pend[i] = 1'b0;
        m_sel[i]  = 1'b0;
        m_sat[i]  = 1'b0;
        m_drop[i] = 0;
      end else begin
        if (fq_a[i].size() != 0 && rdy[i]) begin
          if (mode_of(i) == 0 || m_sel[i]) begin
            void'(fq_a[i].pop_front());
            void'(fq_b[i].pop_front());
          end
          if (mode_of(i) == 1) m_sel[i] = !m_sel[i];
        end
        if (m_pend[i]) begin
          if (fq_a[i].size() < DEPTH) begin
            fq_a[i].push_back(m_pa[i]);
            fq_b[i].push_back(m_pb[i]);
          end else if (m_drop[i] < 65535) begin
            m_drop[i]++;
          end
        end
        m_pend[i] = 1'b0;
        m_sat[i]  = 1'b0;
        if (in_en) begin
          ga = (k >= dly_of(i)) ? acc_g0[k - dly_of(i)] : 0;
          gb = (k >= dly_of(i)) ? acc_g1[k - dly_of(i)] : 0;
          ra = ref_round(longint'(f_in), longint'(ga), ca);
          rb = ref_round(longint'(f_in), longint'(gb), cb);
          if (k >= warm_of(i)) begin
            m_pend[i] = 1'b1;
            m_pa[i]   = ra;
            m_pb[i]   = rb;
            m_sat[i]  = ca || cb;
          end
        end
      end
    end
    if (flush) begin
      acc_g0.delete();
      acc_g1.delete();
    end else if (in_en) begin
      acc_g0.push_back(int'(g0_in));
      acc_g1.push_back(int'(g1_in));
    end
  endtask

  task automatic check_all();
    bit v;
    int ea, eb, n;
    for (int i = 0; i < NI; i++) begin
      n  = fq_a[i].size();
      v  = (n != 0);
      ea = 0;
      eb = 0;
      if (v) begin
        if (mode_of(i) == 1) begin
          ea = m_sel[i] ? fq_b[i][0] : fq_a[i][0];
        end else begin
          ea = fq_a[i][0];
          eb = fq_b[i][0];
        end
      end
      chk($sformatf("u%0d.out_valid", i),   ov[i],   v);
      chk($sformatf("u%0d.x0_out", i),      x0[i],   ea);
      chk($sformatf("u%0d.x1_out", i),      x1[i],   eb);
      chk($sformatf("u%0d.out_sel", i),     sel[i],  m_sel[i]);
      chk($sformatf("u%0d.almost_full", i), af[i],   (n >= DEPTH - 2));
      chk($sformatf("u%0d.sat", i),         sat[i],  m_sat[i]);
      chk($sformatf("u%0d.drop_cnt", i),    drop[i], m_drop[i]);
    end
  endtask

  task automatic cycle();
    if (cap_on && ov[cap_i] && rdy[cap_i]) begin
      cap_x.push_back(int'(x0[cap_i]));
      cap_s.push_back(int'(sel[cap_i]));
    end
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    check_all();
    if (cap_on && sat[cap_i]) n_sat++;
  endtask

  task automatic acc(input int f, input int a, input int b);
    in_en = 1'b1;
    f_in  = 17'(f);
    g0_in = 16'(a);
    g1_in = 16'(b);
    rec_f.push_back(f);
    rec_g0.push_back(a);
    rec_g1.push_back(b);
    cycle();
    in_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    rec_f.delete();
    rec_g0.delete();
    rec_g1.delete();
    cap_x.delete();
    cap_s.delete();
    n_sat = 0;
  endtask

  function automatic int rf();  return int'($urandom_range(0, 131071)) - 65536; endfunction
  function automatic int rg();  return int'($urandom_range(0, 65535)) - 32768;  endfunction

  initial begin
    bit c;
    int e;
    reset = 1'b1; flush = 1'b0; in_en = 1'b0;
    f_in = '0; g0_in = '0; g1_in = '0;
    for (int i = 0; i < NI; i++) rdy[i] = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    idle(2);

    // Basic pair on u1: second pair is (8192, -8192)
    rdy[1] = 1'b1;
    acc(0, 16384, -16384);
    acc(16384, 0, 0);
    idle(1);
    chk("basic.ov",  ov[1], 1);
    chk("basic.x0",  x0[1], 8192);
    chk("basic.x1",  x1[1], -8192);
    idle(1);
    chk("basic.empty", ov[1], 0);

    // Latency: valid appears one edge after the accepting edge's product stage
    do_flush();
    acc(100, 200, 300);
    chk("lat.ov_t", ov[1], 0);
    idle(1);
    chk("lat.ov_t1", ov[1], 1);
    idle(2);

    // Rounding and saturation on u1
    do_flush();
    cap_on = 1'b1; cap_i = 1;
    acc(0, 16384, 0);
    acc(1, 16383, 0);
    acc(1, -16384, 0);
    acc(1, 32767, 0);
    acc(65535, 0, 0);
    idle(4);
    cap_on = 1'b0;
    chk("rnd.count", cap_x.size(), 5);
    if (cap_x.size() == 5) begin
      chk("rnd.f0",    cap_x[0], 0);
      chk("rnd.half",  cap_x[1], 1);
      chk("rnd.below", cap_x[2], 0);
      chk("rnd.neg",   cap_x[3], 0);
      chk("rnd.sat",   cap_x[4], 32767);
    end
    chk("rnd.sat_pulses", n_sat, 1);

    // Warm-up and backpressure on u0: 27 accepts, 12 kept, 8 stored, 4 dropped
    for (int i = 0; i < NI; i++) rdy[i] = 1'b0;
    do_flush();
    for (int k = 0; k < 27; k++) acc(rf() / 4, rg(), rg());
    idle(2);
    chk("bp.drop",  drop[0], 4);
    chk("bp.af",    af[0], 1);
    chk("bp.valid", ov[0], 1);
    cap_on = 1'b1; cap_i = 0;
    rdy[0] = 1'b1;
    idle(10);
    cap_on = 1'b0;
    chk("bp.drained", cap_x.size(), 8);
    for (int j = 0; j < 8 && j < cap_x.size(); j++) begin
      e = ref_round(rec_f[15 + j], rec_g0[15 + j - 12], c);
      chk($sformatf("bp.order%0d", j), cap_x[j], e);
    end
    rdy[0] = 1'b0;

    // MODE 1 serialisation on u2 with toggling ready
    do_flush();
    for (int k = 0; k < 4; k++) acc(rf() / 8, rg(), rg());
    idle(1);
    cap_on = 1'b1; cap_i = 2;
    for (int t = 0; t < 20; t++) begin
      rdy[2] = (t % 2 == 0);
      cycle();
    end
    cap_on = 1'b0;
    rdy[2] = 1'b0;
    chk("m1.count", cap_x.size(), 8);
    for (int j = 0; j < 8 && j < cap_x.size(); j++) begin
      if (j % 2 == 0)
        e = (j / 2 >= 1) ? ref_round(rec_f[j / 2], rec_g0[j / 2 - 1], c) : 0;
      else
        e = (j / 2 >= 1) ? ref_round(rec_f[j / 2], rec_g1[j / 2 - 1], c) : 0;
      chk($sformatf("m1.x%0d", j), cap_x[j], e);
      chk($sformatf("m1.sel%0d", j), cap_s[j], j % 2);
    end

    // Randomized traffic with occasional flushes
    for (int t = 0; t < 1500; t++) begin
      in_en = ($urandom_range(0, 3) != 0);
      f_in  = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'(rf() / 8);
      g0_in = 16'($urandom);
      g1_in = 16'($urandom);
      flush = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NI; i++) rdy[i] = ($urandom_range(0, 2) != 0);
      cycle();
    end
    flush = 1'b0;
    in_en = 1'b0;

    // Flush on the same edge as an accept
    for (int i = 0; i < NI; i++) rdy[i] = 1'b0;
    for (int k = 0; k < 30; k++) acc(rf(), rg(), rg());
    idle(1);
    chk("fl.pre_drop", (drop[1] != 0), 1);
    flush = 1'b1;
    in_en = 1'b1;
    f_in  = 17'(1000);
    g0_in = 16'(2000);
    g1_in = 16'(3000);
    cycle();
    flush = 1'b0;
    in_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("fl.ov%0d", i),   ov[i], 0);
      chk($sformatf("fl.drop%0d", i), drop[i], 0);
    end
    acc(16384, 1000, 1000);
    idle(1);
    chk("fl.tap_zero_v",  ov[1], 1);
    chk("fl.tap_zero_x0", x0[1], 0);
    chk("fl.tap_zero_x1", x1[1], 0);

    // Async reset in the middle of a drain
    for (int k = 0; k < 10; k++) acc(rf() / 4, rg(), rg());
    for (int i = 0; i < NI; i++) rdy[i] = 1'b1;
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ar.ov%0d", i),   ov[i], 0);
      chk($sformatf("ar.x0_%0d", i),  x0[i], 0);
      chk($sformatf("ar.x1_%0d", i),  x1[i], 0);
      chk($sformatf("ar.af%0d", i),   af[i], 0);
      chk($sformatf("ar.sel%0d", i),  sel[i], 0);
      chk($sformatf("ar.sat%0d", i),  sat[i], 0);
      chk($sformatf("ar.drop%0d", i), drop[i], 0);
    end
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
